// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and helpers for the bit-serial subtractor
//
// Contents:
//   state_t        controller states (IDLE, RUN, DONE)
//   cnt_width()    bit-counter width for a W-bit operand
// Optional feature macro used by the bundle: SERIAL_SUB_OVF_EN

package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter walks 0..W-1, so $clog2(W) bits are enough (W >= 2).
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - operand/result handshake bundle for serial_sub
//
// Signals:
//   start, a, b, bin   request and operands (controller -> subtractor)
//   busy, done         progress / one-cycle completion pulse
//   d, bout            difference and borrow-out
//   ovf                signed overflow, only with SERIAL_SUB_OVF_EN
// Modports: master (controller side), slave (subtractor side).

interface serial_sub_if #(
    parameter int W = 4
) ();

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout, ovf
    );
`else
    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout
    );
`endif

endinterface

// File: rtl/serial_sub_full_sub.sv
// rtl/serial_sub_full_sub.sv - combinational one-bit full subtractor
//
// Ports:
//   x, y, bi   minuend bit, subtrahend bit, borrow-in
//   diff, bo   difference bit, borrow-out

module full_sub (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ bi;
    // Borrow when x < y, or when x == y and a borrow is already pending.
    assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial W-bit subtractor, D = A - B - Bin, LSB first
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     serial_sub_if.slave: start/a/b/bin in; busy/done/d/bout out
//           (plus ovf when SERIAL_SUB_OVF_EN is defined)
// A start is accepted in IDLE or DONE; the result appears W cycles later
// with a one-cycle done pulse. Starts during RUN are ignored.

module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  bus
);

    localparam int CW = cnt_width(W);

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-2:0]   res_sh;
    logic           brw;
    logic [CW-1:0]  cnt;

    logic           accept;
    logic           last;
    logic           bit_d;
    logic           bo_d;
    logic [W-1:0]   res_next;

    full_sub u_full_sub (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bi   (brw),
        .diff (bit_d),
        .bo   (bo_d)
    );

    // New bit enters at the MSB end; after W shifts bit 0 sits at the LSB.
    assign res_next = {bit_d, res_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == CW'(W - 1)) begin
                    last    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            res_sh <= '0;
            brw    <= bus.bin;
            cnt    <= '0;
        end else if (state_q == ST_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next[W-1:1];
            brw    <= bo_d;
            cnt    <= cnt + CW'(1);
        end
    end

    // Visible results move only on the final RUN cycle so they stay stable
    // across the whole next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.d    <= '0;
            bus.bout <= 1'b0;
        end else if (last) begin
            bus.d    <= res_next;
            bus.bout <= bo_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // On the last cycle brw is the borrow into the MSB and bo_d the borrow
    // out of it; they differ exactly when the signed result overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ovf <= 1'b0;
        end else if (last) begin
            bus.ovf <= brw ^ bo_d;
        end
    end
`endif

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial W-bit subtractor with a borrow chain. It is the inverse companion to the team's parallel ripple-carry adder. It computes D = A − B − Bin one bit per clock, LSB first, through a single registered full-subtractor cell, trading latency for area. A start/busy/done handshake lets a controller issue operations back-to-back.

## Interface
- W, default 4: operand and result width; W ≥ 2.
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when the block can accept (IDLE or DONE).
- a  input  W  minuend; sampled with an accepted start.
- b  input  W  subtrahend; sampled with an accepted start.
- bin  input  1  borrow-in; sampled with an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: d/bout (and ovf) are valid.
- d  output  W  difference (a − b − bin) mod 2^W; held until the next accepted start completes.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: load a_sh←a, b_sh←b, brw←bin, cnt←0; go to RUN.
- RUN, each cycle:
  - bit = a_sh[0] ^ b_sh[0] ^ brw.
  - brw ← (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw).
  - Shift bit into the result register from the MSB end; shift a_sh and b_sh right; cnt←cnt+1.
- RUN, cnt = W−1: final bit is shifted.
  - d ← completed result, bout ← final brw.
  - Go to DONE.
- DONE: done=1 for this cycle.
  - start=1: accept new operands exactly as IDLE (back-to-back); go to RUN.
  - Else go to IDLE.
- start while in RUN is ignored; operands are not re-sampled.
- d and bout change only on the RUN→DONE edge. The intermediate shift register is internal.
- Reset, asynchronous at any time including mid-operation:
  - State IDLE; busy=0, done=0, d=0, bout=0, ovf=0.
  - Internal shift registers, borrow and cnt cleared.
  - In-flight operation discarded; no done is produced for it.

## Timing
- Start accepted at edge k → busy=1 from edge k through edge k+W−1 (W cycles).
- d/bout update and done rises at edge k+W. busy falls at the same edge.
- Latency from accepting edge to done: W cycles. Throughput: one operation per W+1 cycles.
- A start in the DONE cycle is accepted at edge k+W+1. busy is then high again with no idle gap.
- busy and done are never both 1.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - Port ovf exists.
  - At the RUN→DONE edge, ovf ← (borrow into MSB) ^ (borrow out of MSB), i.e. signed two's-complement overflow of a − b − bin.
  - Held with d; reset to 0.
- Undefined: no ovf port and no MSB-borrow capture register. All other behaviour is identical.

## Structure
- Package serial_sub_pkg:
  - State typedef (IDLE, RUN, DONE).
  - Counter width function/constant $clog2(W).
- Sub-module full_sub: combinational one-bit full subtractor (x, y, bi → diff, bo), instantiated once. The borrow register lives in serial_sub.

## Test plan
- W=4: a=9, b=3, bin=0 → after 4 cycles done=1, d=6, bout=0; busy high exactly 4 cycles.
- a=3, b=9, bin=0 → d=10, bout=1. Then a=0, b=0, bin=1 → d=15, bout=1.
- a=8, b=1, bin=0 with SERIAL_SUB_OVF_EN → d=7, bout=0, ovf=1. a=5, b=2 → ovf=0.
- start pulsed with a=1, b=1 during RUN of a=9−3 → ignored; result d=6; no extra done.
- start held high continuously: ops a=9−3, then a=2−5 → done every 5 cycles, d=6 then d=13 with bout=1.
- Assert rst_n=0 at RUN cycle 2 → all outputs 0 immediately. Release and start a=7−7 → d=0, bout=0, done 4 cycles later.
